// File: rtl/uart_frame_ctrl.sv
// Full-duplex UART with independent RX/TX FSMs, mid-bit RX sampling and framing check.
// Optional parity bit on both directions when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_frame_ctrl #(
  parameter int unsigned CLOCK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 busy,
  output logic                 valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_SENSE = 1'(PARITY_ODD);

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  // RX state
  logic [1:0]           rx_sync_q, rx_sync_d;
  state_t               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_hold_q, rx_hold_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;

  // TX state
  state_t               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic rx_s;
  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q    <= 2'b11;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      rx_hold_q    <= 1'b0;
      valid_q      <= 1'b0;
      rx_data_q    <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      rx_sync_q    <= rx_sync_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
      rx_hold_q    <= rx_hold_d;
      valid_q      <= valid_d;
      rx_data_q    <= rx_data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  // RX: synchronise, detect start, sample each bit near its centre
  always_comb begin
    rx_sync_d    = {rx_sync_q[0], rx};
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CNT_W'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_d     = rx_par_q;
    rx_hold_d    = rx_hold_q;
    valid_d      = 1'b0;
    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        // After a low stop bit the line must go high before a new start counts
        if (rx_hold_q) begin
          if (rx_s) rx_hold_d = 1'b0;
        end else if (!rx_s) begin
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s;
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d     = '0;
          valid_d      = 1'b1;
          rx_data_d    = rx_shift_q;
          frame_err_d  = ~rx_s;
          parity_err_d = PAR_EN & ((^rx_shift_q ^ PAR_SENSE) != rx_par_q);
          rx_hold_d    = ~rx_s;
          rx_state_d   = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // TX: each bit value is registered at the start of its CLKS_PER_BIT window
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (send) begin
          tx_shift_d = tx_data;
          tx_par_d   = ^tx_data ^ PAR_SENSE;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_bit_d = '0;
            if (PAR_EN) begin
              tx_d       = tx_par_q;
              tx_state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = ST_STOP;
            end
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          tx_d     = 1'b1;
          if (tx_bit_q == STOP_LAST) begin
            busy_d     = 1'b0;
            tx_state_d = ST_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign rx_data    = rx_data_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl at 12 clk/bit; received frames checked against a scoreboard.
`timescale 1ns/1ps
module tb_uart_frame_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned SB  = 1;
  localparam int unsigned CPB = 12;
`ifdef UART_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FRAME_BITS = 1 + DW + PB + SB;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          rx_line;
  logic          loop_en;
  logic          tx;
  logic          send;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          valid;
  logic [DW-1:0] rx_data;
  logic          frame_err;
  logic          parity_err;

  exp_t sb_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   valid_cnt = 0;
  int   vc;
  int   busy_cnt;
  logic exp_bit;
  logic [7:0] a5 = 8'hA5;

  assign rx = loop_en ? tx : rx_line;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .CLOCK_FREQ_HZ(12000000),
    .BAUD_RATE    (1000000),
    .DATA_BITS    (DW),
    .STOP_BITS    (SB),
    .PARITY_ODD   (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tx        (tx),
    .send      (send),
    .tx_data   (tx_data),
    .busy      (busy),
    .valid     (valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_rx);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    send    = 1'b1;
    tx_data = b;
    @(negedge clk);
    send    = 1'b0;
    tx_data = ~b;
    check("busy_after_send", 32'(busy), 32'd1);
    if (expect_rx) sb_q.push_back({b, 1'b0, 1'b0});
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx_line = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      cycles(CPB);
    end
    if (PB != 0) begin
      rx_line = ^d ^ par_flip;
      cycles(CPB);
    end
    rx_line = stop_bit;
    cycles(CPB);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    cycles(20);
  endtask

  initial begin
    rst     = 1'b1;
    send    = 1'b0;
    tx_data = '0;
    rx_line = 1'b1;
    loop_en = 1'b0;

    // Receive monitor: every valid pulse consumes one scoreboard entry
    fork
      forever begin
        @(negedge clk);
        if (valid === 1'b1) begin
          valid_cnt++;
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'(rx_data), 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(e.d));
            check("frame_err", 32'(frame_err), 32'(e.fe));
            check("parity_err", 32'(parity_err), 32'(e.pe));
          end
        end
      end
    join_none

    cycles(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    cycles(5);

    // 1: A5 waveform and busy length, looped back into RX
    loop_en = 1'b1;
    send    = 1'b1;
    tx_data = a5;
    @(negedge clk);
    send    = 1'b0;
    tx_data = 8'h00;
    sb_q.push_back({a5, 1'b0, 1'b0});
    busy_cnt = 0;
    for (int n = 0; n <= int'(FRAME_BITS * CPB); n++) begin
      if (busy === 1'b1) busy_cnt++;
      if ((n % CPB) == CPB / 2) begin
        if (n / CPB == 0) exp_bit = 1'b0;
        else if (n / CPB <= 8) exp_bit = a5[n / CPB - 1];
        else if (PB != 0 && n / CPB == 9) exp_bit = ^a5;
        else exp_bit = 1'b1;
        check($sformatf("tx_bit%0d", n / CPB), 32'(tx), 32'(exp_bit));
      end
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_cnt), 32'(FRAME_BITS * CPB));
    wait_drain();

    // 2: back-to-back loopback frames
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_drain();

    // 3: short glitch is rejected as a false start
    loop_en = 1'b0;
    rx_line = 1'b1;
    cycles(20);
    vc = valid_cnt;
    rx_line = 1'b0;
    cycles(4);
    rx_line = 1'b1;
    cycles(40);
    check("false_start_no_valid", 32'(valid_cnt - vc), 32'd0);
    sb_q.push_back({8'h55, 1'b0, 1'b0});
    drive_frame(8'h55, 1'b1, 1'b0);
    wait_drain();

    // 4: low stop bit gives frame_err, then break hold-off while line stays low
    vc = valid_cnt;
    sb_q.push_back({8'h81, 1'b1, 1'b0});
    drive_frame(8'h81, 1'b0, 1'b0);
    cycles(200);
    check("break_single_valid", 32'(valid_cnt - vc), 32'd1);
    check("break_frame_err_held", 32'(frame_err), 32'd1);
    rx_line = 1'b1;
    cycles(20);
    sb_q.push_back({8'h42, 1'b0, 1'b0});
    drive_frame(8'h42, 1'b1, 1'b0);
    wait_drain();

    // 5: reset mid-TX (bit 3) and mid-RX aborts both
    vc = valid_cnt;
    send_byte(8'hC3, 1'b0);
    rx_line = 1'b0;
    cycles(53);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rx_line = 1'b1;
    cycles(2);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    check("rst_mid_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    cycles(200);
    check("rst_abort_no_valid", 32'(valid_cnt - vc), 32'd0);
    check("rst_abort_tx_idle", 32'(tx), 32'd1);
    loop_en = 1'b1;
    send_byte(8'h5A, 1'b1);
    wait_drain();

`ifdef UART_PARITY_EN
    // 6: even parity on TX and parity error detection on RX
    loop_en = 1'b0;
    send_byte(8'h07, 1'b0);
    cycles(9 * CPB + CPB / 2);
    check("tx_parity_bit", 32'(tx), 32'd1);
    cycles(40);
    sb_q.push_back({8'h07, 1'b0, 1'b1});
    drive_frame(8'h07, 1'b1, 1'b1);
    wait_drain();
    sb_q.push_back({8'h07, 1'b0, 1'b0});
    drive_frame(8'h07, 1'b1, 1'b0);
    wait_drain();
`endif

    cycles(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
